// File: rtl/hist_eq_pkg.sv
// Shared types and defaults for the histogram-equalisation frame path.
// Holds the pixel width, default frame geometry and replay FSM states.
package hist_eq_pkg;

   localparam int PIX_W          = 8;
   localparam int DEF_IMG_WIDTH  = 500;
   localparam int DEF_IMG_HEIGHT = 500;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_WAIT_START,
      ST_PRE,
      ST_LINE,
      ST_HBLK,
      ST_POST
   } replay_state_t;

   // True in every state that drives the regenerated vsync.
   function automatic logic is_replay(replay_state_t s);
      return s inside {ST_PRE, ST_LINE, ST_HBLK, ST_POST};
   endfunction

endpackage

// File: rtl/gray_frame_ram.sv
// Single-port synchronous frame store with one-cycle read latency.
// One port is enough because capture and replay never overlap.
module gray_frame_ram
   import hist_eq_pkg::*;
#(
   parameter int DEPTH  = DEF_IMG_WIDTH * DEF_IMG_HEIGHT,
   parameter int ADDR_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [PIX_W-1:0]  wdata,
   output logic [PIX_W-1:0]  rdata
);

   logic [PIX_W-1:0] mem [DEPTH];
   logic [PIX_W-1:0] rdata_q;

   // NOTE: the array and its read register have no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/hist_frame_replay.sv
// Captures one gray frame and replays it with regenerated vsync/href timing
// when the equaliser asks, so it equalises the same frame that was measured.
module hist_frame_replay
   import hist_eq_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int H_BLANK    = 5,
   parameter int V_PRE      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_img_vsync,
   input  logic             in_img_href,
   input  logic [PIX_W-1:0] in_img_gray,
   input  logic             replay_start,
   output logic             out_img_vsync,
   output logic             out_img_href,
   output logic [PIX_W-1:0] out_img_gray,
   output logic             frame_ready,
   output logic             busy,
   output logic             frame_err
);

   localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
   localparam int ADDR_W = $clog2(NPIX + 1);
   localparam int CNT_W  = $clog2(IMG_WIDTH + V_PRE + H_BLANK + 1);
   localparam int LINE_W = $clog2(IMG_HEIGHT + 1);

   localparam logic [ADDR_W-1:0] NPIX_A   = ADDR_W'(NPIX);
   localparam logic [CNT_W-1:0]  W_LAST   = CNT_W'(IMG_WIDTH - 1);
   localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(V_PRE - 1);
   localparam logic [CNT_W-1:0]  HB_LAST  = CNT_W'(H_BLANK - 1);
   localparam logic [LINE_W-1:0] H_LAST   = LINE_W'(IMG_HEIGHT - 1);

   replay_state_t     state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              frame_err_q, frame_err_d;
   logic              vs_in_q, vs_in_d;
   logic              vsync_i_q, vsync_i_d, href_i_q, href_i_d;
   logic              out_vsync_q, out_vsync_d, out_href_q, out_href_d;
   logic [PIX_W-1:0]  out_gray_q, out_gray_d;
   logic              busy_q, busy_d, frame_ready_q, frame_ready_d;

   logic              ram_we, ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [PIX_W-1:0]  ram_rdata;

   logic vsync_rise, vsync_fall;
   assign vsync_rise = in_img_vsync & ~vs_in_q;
   assign vsync_fall = ~in_img_vsync & vs_in_q;

   gray_frame_ram #(.DEPTH(NPIX), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (in_img_gray),
      .rdata (ram_rdata)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      cnt_d       = cnt_q;
      line_d      = line_q;
      frame_err_d = frame_err_q;
      ram_we      = 1'b0;
      ram_re      = 1'b0;
      ram_addr    = rd_addr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (vsync_rise) begin
               state_d     = ST_CAPTURE;
               wr_addr_d   = '0;
               frame_err_d = 1'b0;
            end
         end
         ST_CAPTURE: begin
            ram_addr = wr_addr_q;
            if (in_img_href) begin
               if (wr_addr_q != NPIX_A) begin
                  ram_we    = 1'b1;
                  wr_addr_d = wr_addr_q + 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            // A frame is only kept if it filled the buffer exactly.
            if (vsync_fall) begin
               if (wr_addr_q == NPIX_A && !frame_err_d) begin
                  state_d = ST_WAIT_START;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
         end
         ST_WAIT_START: begin
            if (replay_start) begin
               state_d   = ST_PRE;
               rd_addr_d = '0;
               line_d    = '0;
               cnt_d     = '0;
            end
         end
         ST_PRE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == PRE_LAST) begin
               cnt_d   = '0;
               state_d = ST_LINE;
            end
         end
         ST_LINE: begin
            ram_re    = 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == W_LAST) begin
               cnt_d = '0;
               if (line_q == H_LAST) begin
                  state_d = ST_POST;
               end else begin
                  line_d  = line_q + 1'b1;
                  state_d = ST_HBLK;
               end
            end
         end
         ST_HBLK: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HB_LAST) begin
               cnt_d   = '0;
               state_d = ST_LINE;
            end
         end
         ST_POST:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Internal timing is registered once, then delayed again to meet the RAM read data.
      vs_in_d       = in_img_vsync;
      vsync_i_d     = is_replay(state_q);
      href_i_d      = (state_q == ST_LINE);
      out_vsync_d   = vsync_i_q;
      out_href_d    = href_i_q;
      out_gray_d    = href_i_q ? ram_rdata : '0;
      busy_d        = is_replay(state_d);
      frame_ready_d = (state_d == ST_WAIT_START);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         wr_addr_q     <= '0;
         rd_addr_q     <= '0;
         cnt_q         <= '0;
         line_q        <= '0;
         frame_err_q   <= 1'b0;
         vs_in_q       <= 1'b0;
         vsync_i_q     <= 1'b0;
         href_i_q      <= 1'b0;
         out_vsync_q   <= 1'b0;
         out_href_q    <= 1'b0;
         out_gray_q    <= '0;
         busy_q        <= 1'b0;
         frame_ready_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         rd_addr_q     <= rd_addr_d;
         cnt_q         <= cnt_d;
         line_q        <= line_d;
         frame_err_q   <= frame_err_d;
         vs_in_q       <= vs_in_d;
         vsync_i_q     <= vsync_i_d;
         href_i_q      <= href_i_d;
         out_vsync_q   <= out_vsync_d;
         out_href_q    <= out_href_d;
         out_gray_q    <= out_gray_d;
         busy_q        <= busy_d;
         frame_ready_q <= frame_ready_d;
      end
   end

   assign out_img_vsync = out_vsync_q;
   assign out_img_href  = out_href_q;
   assign out_img_gray  = out_gray_q;
   assign busy          = busy_q;
   assign frame_ready   = frame_ready_q;
   assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_hist_frame_replay.sv
// Bench for hist_frame_replay on a 4x3 frame: a timeline model of capture and
// replay is compared every cycle, plus hand-computed checks of key cycles.
module tb_hist_frame_replay;

   localparam int W    = 4;
   localparam int H    = 3;
   localparam int VP   = 3;
   localparam int HB   = 2;
   localparam int NPIX = W * H;
   localparam int R    = VP + H * W + (H - 1) * HB + 1;  // replay states incl. POST

   logic       clk = 1'b0;
   logic       rst, in_vsync, in_href, replay_start;
   logic [7:0] in_gray;
   logic       out_vsync, out_href, frame_ready, busy, frame_err;
   logic [7:0] out_gray;

   hist_frame_replay #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB), .V_PRE(VP)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_img_vsync  (in_vsync),
      .in_img_href   (in_href),
      .in_img_gray   (in_gray),
      .replay_start  (replay_start),
      .out_img_vsync (out_vsync),
      .out_img_href  (out_href),
      .out_img_gray  (out_gray),
      .frame_ready   (frame_ready),
      .busy          (busy),
      .frame_err     (frame_err)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   bit chk_en = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Timeline model: capture bookkeeping plus a cycle index since the replay trigger.
   typedef enum {M_IDLE, M_CAP, M_READY, M_REPLAY} mmode_t;
   mmode_t     mmode = M_IDLE;
   bit         m_err, m_prev_vs, m_active;
   int         m_rs;
   logic [7:0] m_frame [NPIX];
   logic [7:0] m_cap [$];

   always @(posedge clk) begin
      if (rst) begin
         mmode = M_IDLE; m_err = 0; m_prev_vs = 0; m_active = 0; m_rs = 0;
      end else begin
         if (m_active) begin
            m_rs++;
            if (m_rs > R + 2) m_active = 0;
         end
         case (mmode)
            M_IDLE: if (in_vsync && !m_prev_vs) begin
               mmode = M_CAP; m_cap.delete(); m_err = 0;
            end
            M_CAP: begin
               if (in_href) begin
                  if (m_cap.size() < NPIX) m_cap.push_back(in_gray);
                  else m_err = 1;
               end
               if (!in_vsync && m_prev_vs) begin
                  if (m_cap.size() == NPIX && !m_err) begin
                     mmode = M_READY;
                     for (int i = 0; i < NPIX; i++) m_frame[i] = m_cap[i];
                  end else begin
                     m_err = 1; mmode = M_IDLE;
                  end
               end
            end
            M_READY: if (replay_start) begin
               mmode = M_REPLAY; m_active = 1; m_rs = 0;
            end
            M_REPLAY: if (m_rs == R) mmode = M_IDLE;
            default: mmode = M_IDLE;
         endcase
         m_prev_vs = in_vsync;
      end
   end

   logic       e_vs, e_hr, e_busy, e_rdy;
   logic [7:0] e_g;
   int         e_k;

   always @(negedge clk) begin
      if (chk_en) begin
         e_vs = m_active && m_rs >= 2 && m_rs <= R + 1;
         e_hr = 1'b0;
         e_g  = 8'h00;
         if (m_active && m_rs >= 2 + VP) begin
            e_k = m_rs - 2 - VP;
            if (e_k / (W + HB) < H && e_k % (W + HB) < W) begin
               e_hr = 1'b1;
               e_g  = m_frame[(e_k / (W + HB)) * W + e_k % (W + HB)];
            end
         end
         e_busy = (mmode == M_REPLAY);
         e_rdy  = (mmode == M_READY);
         n_vec++;
         if ({out_vsync, out_href, out_gray, busy, frame_ready, frame_err} !==
             {e_vs, e_hr, e_g, e_busy, e_rdy, m_err}) begin
            n_miss++;
            $display("FAIL stream @%0t: got vs=%b hr=%b g=%02h busy=%b rdy=%b err=%b, expected vs=%b hr=%b g=%02h busy=%b rdy=%b err=%b",
                     $time, out_vsync, out_href, out_gray, busy, frame_ready, frame_err,
                     e_vs, e_hr, e_g, e_busy, e_rdy, m_err);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      replay_start = 1'b1;
      tick();
      replay_start = 1'b0;
   endtask

   // n pixels in rows of W with 2-cycle href gaps; optional replay_start on pixel start_at.
   task automatic send_frame(input int n, input logic [7:0] first, input int start_at);
      in_vsync = 1'b1;
      repeat (2) tick();
      for (int i = 0; i < n; i++) begin
         if (i == start_at) replay_start = 1'b1;
         in_href = 1'b1;
         in_gray = first + 8'(i);
         tick();
         replay_start = 1'b0;
         if ((i + 1) % W == 0) begin
            in_href = 1'b0; in_gray = 8'h00;
            repeat (2) tick();
         end
      end
      in_href = 1'b0; in_gray = 8'h00;
      tick();
      in_vsync = 1'b0;
      repeat (3) tick();
   endtask

   logic       r_vs [30];
   logic       r_hr [30];
   logic       r_busy [30];
   logic [7:0] r_g [30];

   // Index s = cycles after the edge that sampled replay_start.
   task automatic record();
      for (int s = 0; s < 30; s++) begin
         @(negedge clk);
         r_vs[s] = out_vsync; r_hr[s] = out_href; r_g[s] = out_gray; r_busy[s] = busy;
      end
   endtask

   initial begin
      int         cnt;
      logic       prev, seen;
      logic [7:0] exp_px;

      rst = 1'b1; in_vsync = 1'b0; in_href = 1'b0; in_gray = 8'h00; replay_start = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk_en = 1;
      @(negedge clk);
      check("rst_vsync", out_vsync, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", frame_ready, 0);
      check("rst_err", frame_err, 0);

      // Good frame 01..0C, single pulse.
      send_frame(NPIX, 8'h01, -1);
      check("t1_ready", frame_ready, 1);
      check("t1_err", frame_err, 0);
      pulse_start();
      record();
      check("t1_vs_s1", r_vs[1], 0);
      check("t1_vs_s2", r_vs[2], 1);
      check("t1_href_s4", r_hr[4], 0);
      check("t1_href_s5", r_hr[5], 1);
      check("t1_gap_s9", r_hr[9], 0);
      check("t1_gap_s10", r_hr[10], 0);
      check("t1_last_s20", r_g[20], 8'h0C);
      check("t1_vs_s21", r_vs[21], 1);
      check("t1_vs_s22", r_vs[22], 0);
      check("t1_busy_s19", r_busy[19], 1);
      check("t1_busy_s20", r_busy[20], 0);
      cnt = 0;
      exp_px = 8'h01;
      for (int s = 0; s < 30; s++) begin
         if (r_hr[s]) begin
            check($sformatf("t1_pix%0d", cnt), r_g[s], exp_px);
            exp_px++;
            cnt++;
         end
      end
      check("t1_n_href", cnt, NPIX);

      // Short frame: error, nothing to replay.
      send_frame(NPIX - 1, 8'h01, -1);
      check("t2_err", frame_err, 1);
      check("t2_ready", frame_ready, 0);
      pulse_start();
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen |= out_vsync;
      end
      check("t2_no_replay", seen, 0);

      // Long frame: error, back to idle.
      send_frame(NPIX + 1, 8'h01, -1);
      check("t3_err", frame_err, 1);
      check("t3_ready", frame_ready, 0);
      check("t3_busy", busy, 0);

      // Pulse during capture ignored; a held level replays only once.
      send_frame(NPIX, 8'h21, 5);
      check("t4_ready", frame_ready, 1);
      check("t4_busy", busy, 0);
      check("t4_err", frame_err, 0);
      replay_start = 1'b1;
      cnt = 0;
      prev = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_vsync && !prev) cnt++;
         prev = out_vsync;
      end
      replay_start = 1'b0;
      check("t4_one_replay", cnt, 1);

      // Reset on the 2nd pixel of the second line.
      send_frame(NPIX, 8'h41, -1);
      pulse_start();
      repeat (13) @(negedge clk);
      check("t5_pix_before_rst", out_gray, 8'h46);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t5_vsync", out_vsync, 0);
      check("t5_href", out_href, 0);
      check("t5_gray", out_gray, 0);
      check("t5_busy", busy, 0);
      check("t5_ready", frame_ready, 0);
      rst = 1'b0;
      tick();

      // Fresh capture replays; a frame arriving during replay is lost.
      send_frame(NPIX, 8'h51, -1);
      pulse_start();
      fork
         begin
            repeat (3) tick();
            send_frame(NPIX, 8'h91, -1);
         end
         record();
      join
      check("t6_first", r_g[5], 8'h51);
      check("t6_last", r_g[20], 8'h5C);
      check("t6_ready_after", frame_ready, 0);
      check("t6_busy_after", busy, 0);

      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
